// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered reads and a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read port.
module regfile_2r1w #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int DATA_D   = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(DATA_D);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DATA_D - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   mem [DATA_D];
    logic                wr_ok;
    logic [DATA_W-1:0]   rd0_p0;
    logic [DATA_W-1:0]   rd1_p0;

    // An address is live when it maps to a physical entry that is not the hardwired zero.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range  = ({1'b0, a} < DEPTH);
        is_zero   = (ZERO_REG != 0) && (a == '0);
        addr_live = in_range && !is_zero;
    endfunction

    // A clear request in IDLE wins over a write on the same edge.
    assign wr_ok = !we_ && !busy && !clr && addr_live(waddr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_D; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Stage p0: combinational read select
    always_comb begin
        rd0_p0 = '0;
        rd1_p0 = '0;
        if (addr_live(raddr0)) begin
            rd0_p0 = mem[raddr0];
        end
        if (addr_live(raddr1)) begin
            rd1_p0 = mem[raddr1];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == raddr0)) begin
            rd0_p0 = wdata;
        end
        if (wr_ok && (waddr == raddr1)) begin
            rd1_p0 = wdata;
        end
`endif
    end

    // Stage p1: registered read outputs, forced to zero while the clear runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (busy) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            rdata0 <= rd0_p0;
            rdata1 <= rd1_p0;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w at default parameters (32 x 32-bit, entry 0 hardwired).
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we_ = 1'b1;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr0 = '0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        clr = 1'b0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    regfile_2r1w dut (
        .clk    (clk),
        .reset  (reset),
        .we_    (we_),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .clr    (clr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we_   = 1'b0;
        waddr = a;
        wdata = d;
        tick();
        we_   = 1'b1;
    endtask

    task automatic do_read(input logic [4:0] a0, input logic [4:0] a1,
                           output logic [31:0] r0, output logic [31:0] r1);
        raddr0 = a0;
        raddr1 = a1;
        tick();
        r0 = rdata0;
        r1 = rdata1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b rd0=%h rd1=%h, want 0/0/0", busy, rdata0, rdata1);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_held: busy=%b rd0=%h rd1=%h, want 0/0/0", busy, rdata0, rdata1);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_reg();
        logic [31:0] r0, r1;
        raddr0 = 5'd0;
        raddr1 = 5'd0;
        do_write(5'd0, 32'hDEADBEEF);
        vectors++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_same_edge: rd0=%h rd1=%h, want 0", rdata0, rdata1);
        end
        do_read(5'd0, 5'd0, r0, r1);
        vectors++;
        if (r0 !== 32'h0 || r1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_reg: rd0=%h rd1=%h, want 0", r0, r1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] r0, r1;
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h55;
`else
        exp_same = 32'h0;
`endif
        raddr0 = 5'd7;
        raddr1 = 5'd8;
        do_write(5'd7, 32'h55);
        vectors++;
        if (rdata0 !== exp_same) begin
            miscompares++;
            $display("FAIL bypass_rd0: got %h, want %h", rdata0, exp_same);
        end
        vectors++;
        if (rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_rd1_other: got %h, want 0", rdata1);
        end
        do_read(5'd7, 5'd7, r0, r1);
        vectors++;
        if (r0 !== 32'h55 || r1 !== 32'h55) begin
            miscompares++;
            $display("FAIL bypass_after: rd0=%h rd1=%h, want 55", r0, r1);
        end
    endtask

    task automatic test_fill_read();
        logic [31:0] r0, r1;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            do_read(5'(i), 5'(32 - i), r0, r1);
            vectors++;
            if (r0 !== 32'(i)) begin
                miscompares++;
                $display("FAIL fill_rd0[%0d]: got %h, want %h", i, r0, i);
            end
            vectors++;
            if (r1 !== 32'(32 - i)) begin
                miscompares++;
                $display("FAIL fill_rd1[%0d]: got %h, want %h", 32 - i, r1, 32 - i);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] r0, r1;
        int n;
        raddr0 = 5'd31;
        raddr1 = 5'd30;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        we_ = 1'b0;
        waddr = 5'd5;
        wdata = 32'hFFFF_FFFF;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
            if (busy === 1'b1) begin
                vectors++;
                if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
                    miscompares++;
                    $display("FAIL clear_read_busy[%0d]: rd0=%h rd1=%h, want 0", n, rdata0, rdata1);
                end
            end
        end
        we_ = 1'b1;
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL clear_busy_cycles: got %0d, want 32", n);
        end
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i), r0, r1);
            vectors++;
            if (r0 !== 32'h0 || r1 !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_entry[%0d]: rd0=%h rd1=%h, want 0", i, r0, r1);
            end
        end
    endtask

    task automatic test_clr_write();
        logic [31:0] r0, r1;
        int n;
        do_write(5'd4, 32'h99);
        clr   = 1'b1;
        we_   = 1'b0;
        waddr = 5'd4;
        wdata = 32'h12;
        tick();
        we_ = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 4) clr = 1'b0;
            tick();
        end
        clr = 1'b0;
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL clr_no_restart: busy cycles %0d, want 32", n);
        end
        do_read(5'd4, 5'd4, r0, r1);
        vectors++;
        if (r0 !== 32'h0 || r1 !== 32'h0) begin
            miscompares++;
            $display("FAIL clr_write_entry4: rd0=%h rd1=%h, want 0", r0, r1);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] r0, r1;
        logic [31:0] exp;
        do_write(5'd3, 32'h33);
        do_write(5'd20, 32'h20);
        do_write(5'd31, 32'h31);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: busy=%b rd0=%h rd1=%h, want 0/0/0", busy, rdata0, rdata1);
        end
        tick();
        reset = 1'b0;
        do_write(5'd3, 32'hA5);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_after: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 32; i++) begin
            exp = (i == 3) ? 32'hA5 : 32'h0;
            do_read(5'(i), 5'(i), r0, r1);
            vectors++;
            if (r0 !== exp || r1 !== exp) begin
                miscompares++;
                $display("FAIL post_reset_entry[%0d]: rd0=%h rd1=%h, want %h", i, r0, r1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_fill_read();
        test_clear();
        test_clr_write();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
